pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS32-style core; no forwarding network.
//  Tracks destination registers of in-flight instructions (EX/MEM/WB scoreboard) and stalls ID on RAW hazards.
//  Holds EX for multi-cycle MUL, flushes wrong-path fetches on taken branch, and drains/halts on HALT.
//  Drives the pipeline-register enables/bubbles; the datapath stages stay purely combinational.
// PARAMETERS
//  MUL_LAT    3  EX occupancy of MUL in cycles, legal 1..15 (1 = no extra stall)
//  WB_BYPASS  0  1: regfile writes before read, so a WB-stage match is not a hazard
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   asynchronous active-low reset
//  ir_id         in   32  instruction in IF/ID register
//  id_valid      in   1   IF/ID holds a real instruction (0 = bubble, no sources/dest)
//  br_taken      in   1   EX branch condition (sel); meaningful only when EX holds a branch
//  pc_we         out  1   PC update enable
//  ifid_we       out  1   IF/ID load enable
//  ifid_flush    out  1   IF/ID load NOP instead of fetched word
//  idex_we       out  1   ID/EX load enable
//  idex_bubble   out  1   ID/EX load NOP (valid=0)
//  exmem_bubble  out  1   EX/MEM load NOP (valid=0)
//  halted        out  1   core drained and stopped
//  stall_cnt     out  16  saturating count of hazard + MUL stall cycles
// BEHAVIOUR
//  Decode (op=ir[31:26], rs=[25:21], rt=[20:16], rd=[15:11]):
//   op[5:4]=00 RR ALU: src rs,rt; dst rd.  op[5:4]=01 imm ALU: src rs; dst rt.
//   MUL = op[5]=0 && op[3:0]=2 (RR or imm).  100000 LW: src rs; dst rt.  100001 SW: src rs,rt; no dst.
//   11010x BEQZ/BNEZ: src rs; no dst.  111111 HALT.  Other: no src/dst.  dst=r0 is never recorded.
//  Scoreboard: 3 entries {v,dst[4:0]} for EX,MEM,WB; shifts every cycle:
//   WB<=MEM; MEM<=(mul_busy ? invalid : EX); EX<=(mul_busy ? hold : idex_bubble ? invalid : ID dst).
//  hazard = id_valid && some nonzero src equals a valid dst in EX, MEM, or WB (WB ignored if WB_BYPASS=1).
//  mul_busy = mul_cnt!=0; mul_cnt loads MUL_LAT-1 when a MUL enters ID/EX, decrements to 0.
//  Priority per cycle (combinational outputs):
//   1 br_taken: pc_we=1, ifid_flush=1, idex_bubble=1 (both younger instrs squashed; ID not recorded).
//   2 mul_busy: pc_we=ifid_we=idex_we=0, exmem_bubble=1; stall_cnt++.
//   3 hazard: pc_we=ifid_we=0, idex_bubble=1; stall_cnt++.
//   4 HALT in ID: pc_we=ifid_we=0, idex_bubble=1; FSM->DRAIN.
//   5 else all enables 1, bubbles/flush 0.
//  FSM: RUN -> DRAIN (HALT accepted, case 4) -> HALTED when scoreboard empty and !mul_busy.
//   DRAIN/HALTED: pc_we=ifid_we=0, idex_bubble=1; br_taken cannot occur in DRAIN (EX is younger than HALT) and is ignored.
//   HALTED: halted=1, sticky until reset.
//  stall_cnt saturates at 0xFFFF; branch/HALT/DRAIN cycles do not count.
//  Reset (async, any time incl. mid-MUL/DRAIN): scoreboard invalid, mul_cnt=0, FSM=RUN, stall_cnt=0;
//   while rst_n=0: pc_we=ifid_we=idex_we=0, ifid_flush=0, idex_bubble=exmem_bubble=1, halted=0.
// TESTING
//  T1 reset mid-MUL and mid-DRAIN -> outputs at reset values same cycle; after release, clean RUN, stall_cnt=0.
//  T2 ADD r3,r1,r2 (0x00221800) then SUB r4,r3,r1 (0x04612000) -> idex_bubble=1, pc_we=0 for 3 cycles (2 if WB_BYPASS=1); stall_cnt=3 (2).
//  T3 MUL r5,r1,r2 (0x08222800), MUL_LAT=3, then independent ADD -> 2 cycles pc_we=idex_we=0, exmem_bubble=1; MUL reaches MEM once.
//  T4 br_taken=1 while ID has RAW hazard -> ifid_flush=1, idex_bubble=1, pc_we=1; stall_cnt unchanged; squashed dsts absent from scoreboard.
//  T5 ADDI r0,r1,5 (0x40200005) then ADD r2,r0,r0 -> no stall.
//  T6 HALT (0xFC000000) behind 2 in-flight ALU ops -> pc_we=0 at once; halted=1 once WB empties (3rd cycle); holds until rst_n low.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/drain sequencer for a 5-stage in-order core with no forwarding network.
// Keeps an EX/MEM/WB destination scoreboard, holds EX for multi-cycle MUL and drains the pipe on HALT.
module pipe_ctrl #(
  parameter int unsigned MUL_LAT   = 3,
  parameter bit          WB_BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir_id,
  input  logic        id_valid,
  input  logic        br_taken,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  // One scoreboard entry against both ID sources; r0 never creates a dependency.
  function automatic logic entry_hit(
    input logic       ent_v,
    input logic [4:0] ent_dst,
    input logic       s1_v,
    input logic [4:0] s1,
    input logic       s2_v,
    input logic [4:0] s2
  );
    return ent_v && ((s1_v && (s1 != 5'd0) && (s1 == ent_dst)) ||
                     (s2_v && (s2 != 5'd0) && (s2 == ent_dst)));
  endfunction

  state_e      state_q, state_d;
  logic        ex_v_q, mem_v_q, wb_v_q;
  logic [4:0]  ex_dst_q, mem_dst_q, wb_dst_q;
  logic        ex_v_d, mem_v_d, wb_v_d;
  logic [4:0]  ex_dst_d, mem_dst_d, wb_dst_d;
  logic [3:0]  mul_cnt_q, mul_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [5:0]  op_s;
  logic [4:0]  rs_s, rt_s, rd_s;
  logic        src1_v_s, src2_v_s, dst_v_s, is_halt_s, is_mul_s;
  logic [4:0]  dst_s;
  logic        id_dst_v_s;
  logic        hazard_s, mul_busy_s, sb_empty_s;

  logic        pc_we_s, ifid_we_s, ifid_flush_s, idex_we_s, idex_bubble_s, exmem_bubble_s;
  logic        halted_s, stall_evt_s, halt_acc_s, issue_s;

  assign op_s = ir_id[31:26];
  assign rs_s = ir_id[25:21];
  assign rt_s = ir_id[20:16];
  assign rd_s = ir_id[15:11];

  assign is_mul_s = ~op_s[5] & (op_s[3:0] == 4'd2);

  // Source/destination decode of the instruction waiting in IF/ID.
  always_comb begin
    src1_v_s  = 1'b0;
    src2_v_s  = 1'b0;
    dst_v_s   = 1'b0;
    dst_s     = 5'd0;
    is_halt_s = 1'b0;
    if (op_s[5:4] == 2'b00) begin
      src1_v_s = 1'b1;
      src2_v_s = 1'b1;
      dst_v_s  = 1'b1;
      dst_s    = rd_s;
    end else if (op_s[5:4] == 2'b01) begin
      src1_v_s = 1'b1;
      dst_v_s  = 1'b1;
      dst_s    = rt_s;
    end else if (op_s == 6'b100000) begin
      src1_v_s = 1'b1;
      dst_v_s  = 1'b1;
      dst_s    = rt_s;
    end else if (op_s == 6'b100001) begin
      src1_v_s = 1'b1;
      src2_v_s = 1'b1;
    end else if (op_s[5:1] == 5'b11010) begin
      src1_v_s = 1'b1;
    end else if (op_s == 6'b111111) begin
      is_halt_s = 1'b1;
    end else begin
      dst_v_s = 1'b0;
    end
  end

  assign id_dst_v_s = id_valid & dst_v_s & (dst_s != 5'd0);
  assign mul_busy_s = (mul_cnt_q != 4'd0);
  assign sb_empty_s = ~ex_v_q & ~mem_v_q & ~wb_v_q;

  assign hazard_s = id_valid & (
      entry_hit(ex_v_q,  ex_dst_q,  src1_v_s, rs_s, src2_v_s, rt_s) |
      entry_hit(mem_v_q, mem_dst_q, src1_v_s, rs_s, src2_v_s, rt_s) |
      ((WB_BYPASS == 1'b0) & entry_hit(wb_v_q, wb_dst_q, src1_v_s, rs_s, src2_v_s, rt_s)));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a HALT is accepted only after branch, MUL and hazard cases lose priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt_acc_s) state_d = ST_DRAIN;
        else            state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (sb_empty_s && !mul_busy_s) state_d = ST_HALTED;
        else                           state_d = ST_DRAIN;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_DRAIN;
    endcase
  end

  // FSM outputs and per-cycle priority resolution.
  always_comb begin
    pc_we_s        = 1'b1;
    ifid_we_s      = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_we_s      = 1'b1;
    idex_bubble_s  = 1'b0;
    exmem_bubble_s = 1'b0;
    halted_s       = 1'b0;
    stall_evt_s    = 1'b0;
    halt_acc_s     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (br_taken) begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
        end else if (mul_busy_s) begin
          pc_we_s        = 1'b0;
          ifid_we_s      = 1'b0;
          idex_we_s      = 1'b0;
          exmem_bubble_s = 1'b1;
          stall_evt_s    = 1'b1;
        end else if (hazard_s) begin
          pc_we_s       = 1'b0;
          ifid_we_s     = 1'b0;
          idex_bubble_s = 1'b1;
          stall_evt_s   = 1'b1;
        end else if (id_valid && is_halt_s) begin
          pc_we_s       = 1'b0;
          ifid_we_s     = 1'b0;
          idex_bubble_s = 1'b1;
          halt_acc_s    = 1'b1;
        end else begin
          pc_we_s   = 1'b1;
          ifid_we_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        pc_we_s        = 1'b0;
        ifid_we_s      = 1'b0;
        idex_bubble_s  = 1'b1;
        exmem_bubble_s = mul_busy_s;
        halted_s       = sb_empty_s & ~mul_busy_s;
      end
      ST_HALTED: begin
        pc_we_s        = 1'b0;
        ifid_we_s      = 1'b0;
        idex_bubble_s  = 1'b1;
        exmem_bubble_s = mul_busy_s;
        halted_s       = 1'b1;
      end
      default: begin
        pc_we_s       = 1'b0;
        ifid_we_s     = 1'b0;
        idex_bubble_s = 1'b1;
      end
    endcase
  end

  assign issue_s = idex_we_s & ~idex_bubble_s;

  // Scoreboard shift, MUL occupancy countdown and saturating stall counter.
  always_comb begin
    wb_v_d    = mem_v_q;
    wb_dst_d  = mem_dst_q;
    mem_v_d   = 1'b0;
    mem_dst_d = 5'd0;
    ex_v_d    = ex_v_q;
    ex_dst_d  = ex_dst_q;
    mul_cnt_d = mul_cnt_q;
    if (mul_busy_s) begin
      mul_cnt_d = mul_cnt_q - 4'd1;
    end else begin
      mem_v_d   = ex_v_q;
      mem_dst_d = ex_dst_q;
      if (idex_bubble_s) begin
        ex_v_d   = 1'b0;
        ex_dst_d = 5'd0;
      end else begin
        ex_v_d   = id_dst_v_s;
        ex_dst_d = id_dst_v_s ? dst_s : 5'd0;
      end
      if (issue_s && id_valid && is_mul_s) mul_cnt_d = MUL_LOAD;
      else                                 mul_cnt_d = 4'd0;
    end
    if (stall_evt_s && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    else                                          stall_cnt_d = stall_cnt_q;
  end

  // Datapath-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q      <= 1'b0;
      ex_dst_q    <= 5'd0;
      mem_v_q     <= 1'b0;
      mem_dst_q   <= 5'd0;
      wb_v_q      <= 1'b0;
      wb_dst_q    <= 5'd0;
      mul_cnt_q   <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      ex_v_q      <= ex_v_d;
      ex_dst_q    <= ex_dst_d;
      mem_v_q     <= mem_v_d;
      mem_dst_q   <= mem_dst_d;
      wb_v_q      <= wb_v_d;
      wb_dst_q    <= wb_dst_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs take their safe values for as long as reset is held, without waiting for a clock.
  assign pc_we        = rst_n & pc_we_s;
  assign ifid_we      = rst_n & ifid_we_s;
  assign ifid_flush   = rst_n & ifid_flush_s;
  assign idex_we      = rst_n & idex_we_s;
  assign idex_bubble  = ~rst_n | idex_bubble_s;
  assign exmem_bubble = ~rst_n | exmem_bubble_s;
  assign halted       = rst_n & halted_s;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a directed program followed by random instruction streams, checked every
// cycle against a timing model that tracks when each register's producer leaves the pipeline.
module tb_pipe_ctrl;
  localparam int MUL_LAT   = 3;
  localparam bit WB_BYPASS = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir_id = 32'd0;
  logic        id_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, halted;
  logic [15:0] stall_cnt;

  pipe_ctrl #(.MUL_LAT(MUL_LAT), .WB_BYPASS(WB_BYPASS)) dut (
    .clk(clk), .rst_n(rst_n), .ir_id(ir_id), .id_valid(id_valid), .br_taken(br_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: ready_at[r] is the first cycle a reader of r may leave ID.
  int          cyc = 0;
  int          ready_at[32];
  int          mul_free = 0;
  int          br_at = -1;
  int          m_state = 0;   // 0 running, 1 draining, 2 halted
  int          halt_cycles = 0;
  logic [15:0] m_cnt = 16'd0;
  logic [31:0] id_word = 32'd0;
  logic        id_v = 1'b0;
  logic [31:0] prog[$];
  bit          rand_mode = 1'b0;
  bit          br_force = 1'b0;

  task automatic decode(input logic [31:0] w, output int sa, output int sb, output int dst,
                        output bit mul, output bit halt, output bit br);
    int op, rs, rt, rd;
    op = int'(w[31:26]);
    rs = int'(w[25:21]);
    rt = int'(w[20:16]);
    rd = int'(w[15:11]);
    sa = 0; sb = 0; dst = 0;
    mul  = (op < 32) && (op % 16 == 2);
    halt = (op == 63);
    br   = (op == 52) || (op == 53);
    if (op < 16) begin sa = rs; sb = rt; dst = rd; end
    else if (op < 32) begin sa = rs; dst = rt; end
    else if (op == 32) begin sa = rs; dst = rt; end
    else if (op == 33) begin sa = rs; sb = rt; end
    else if (br) sa = rs;
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [5:0] op;
    k = $urandom_range(0, 99);
    if (k < 10)      op = ($urandom_range(0, 1) == 1) ? 6'd18 : 6'd2;
    else if (k < 35) op = 6'($urandom_range(0, 15));
    else if (k < 52) op = 6'(16 + $urandom_range(0, 15));
    else if (k < 63) op = 6'd32;
    else if (k < 72) op = 6'd33;
    else if (k < 85) op = 6'(52 + $urandom_range(0, 1));
    else if (k < 88) op = 6'd63;
    else             op = 6'(34 + $urandom_range(0, 17));
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 11'($urandom)};
  endfunction

  task automatic fetch();
    if (prog.size() != 0) begin
      id_word = prog.pop_front();
      id_v    = 1'b1;
    end else if (rand_mode) begin
      id_word = rand_instr();
      id_v    = ($urandom_range(0, 7) != 0);
    end else begin
      id_word = 32'd0;
      id_v    = 1'b0;
    end
  endtask

  // One clock cycle: drive ID, predict, compare at the falling edge, advance the model.
  task automatic step();
    int sa, sb, dst, lat, nxt;
    bit mul, halt, br, haz, mbusy, drained, stall, br_drive;
    bit e_pc, e_ifid, e_flush, e_idexwe, e_bub, e_exb, e_halt;
    decode(id_word, sa, sb, dst, mul, halt, br);
    if (m_state == 2) halt_cycles++;
    mbusy = (cyc < mul_free);
    if (m_state == 0) br_drive = (br_at == cyc) && (br_force || $urandom_range(0, 1) == 1);
    else              br_drive = ($urandom_range(0, 3) == 0);
    ir_id = id_word; id_valid = id_v; br_taken = br_drive;
    haz = id_v && ((sa != 0 && ready_at[sa] > cyc) || (sb != 0 && ready_at[sb] > cyc));
    drained = !mbusy;
    for (int r = 0; r < 32; r++) if (ready_at[r] > cyc) drained = 1'b0;
    e_pc = 1; e_ifid = 1; e_flush = 0; e_idexwe = 1; e_bub = 0; e_exb = 0; e_halt = 0;
    stall = 0; nxt = m_state;
    if (m_state == 0) begin
      if (br_drive) begin
        e_flush = 1; e_bub = 1;
      end else if (mbusy) begin
        e_pc = 0; e_ifid = 0; e_idexwe = 0; e_exb = 1; stall = 1;
      end else if (haz) begin
        e_pc = 0; e_ifid = 0; e_bub = 1; stall = 1;
      end else if (id_v && halt) begin
        e_pc = 0; e_ifid = 0; e_bub = 1; nxt = 1;
      end else if (id_v) begin
        lat = mul ? MUL_LAT : 1;
        if (dst != 0) ready_at[dst] = cyc + lat + (WB_BYPASS ? 2 : 3);
        if (mul) mul_free = cyc + lat;
        if (br) br_at = cyc + 1;
      end
    end else begin
      e_pc = 0; e_ifid = 0; e_bub = 1; e_exb = mbusy;
      e_halt = (m_state == 2) || drained;
      if (m_state == 1 && drained) nxt = 2;
    end
    @(negedge clk);
    check_val("ctrl", {25'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, halted},
              {25'd0, e_pc, e_ifid, e_flush, e_idexwe, e_bub, e_exb, e_halt});
    check_val("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_cnt});
    if (stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_state = nxt;
    if (e_ifid) begin
      if (e_flush) begin id_v = 1'b0; id_word = 32'd0; end
      else fetch();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop to safe values immediately.
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    id_valid = 1'b0;
    br_taken = 1'b0;
    #1;
    check_val("rst_ctrl", {25'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, halted},
              32'h0000_0006);
    check_val("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    mul_free = 0; br_at = -1; m_state = 0; m_cnt = 16'd0; halt_cycles = 0;
    id_v = 1'b0; id_word = 32'd0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    #1;
    do_reset(2);

    // Directed program: RAW stall, MUL hold, r0 writes, branch over a hazard, HALT drain.
    rand_mode = 1'b0;
    br_force  = 1'b1;
    prog.push_back(32'h0022_1800);  // ADD r3,r1,r2
    prog.push_back(32'h0461_2000);  // SUB r4,r3,r1
    prog.push_back(32'h0822_2800);  // MUL r5,r1,r2
    prog.push_back(32'h0022_3000);  // ADD r6,r1,r2
    prog.push_back(32'h4020_0005);  // ADDI r0,r1,5
    prog.push_back(32'h0000_5000);  // ADD r10,r0,r0
    prog.push_back(32'h0022_3800);  // ADD r7,r1,r2
    prog.push_back(32'hD000_0000);  // BEQZ r0
    prog.push_back(32'h04E1_2000);  // SUB r4,r7,r1 (squashed)
    prog.push_back(32'h0022_4000);  // ADD r8,r1,r2
    prog.push_back(32'h0022_4800);  // ADD r9,r1,r2
    prog.push_back(32'hFC00_0000);  // HALT
    for (int i = 0; i < 80 && halt_cycles < 4; i++) step();
    check_val("dir_halted", {31'd0, halted}, 32'd1);
    check_val("dir_stall_cnt", {16'd0, stall_cnt}, 32'd5);
    do_reset(1);

    // Random streams with resets dropped in mid-MUL, mid-drain and after halting.
    rand_mode = 1'b1;
    br_force  = 1'b0;
    prog.delete();
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 2 && halt_cycles >= 3)
        do_reset(1 + $urandom_range(0, 1));
      else if ((cyc < mul_free || m_state == 1) && $urandom_range(0, 9) == 0)
        do_reset(1);
      else
        step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
